weapon_article_locator: RTL
===========================

// Module: weapon_article_locator
// PURPOSE
//  Upstream stage of the weapon-article sprite ROM. Tracks the on-screen position and lifecycle of a dropped weapon:
//  hidden, then falling, then resting. Compares the live VGA beam (hc, vc) against the sprite window.
//  Emits is_in_pixel plus sprite-local loc_hc/loc_vc. The ROM stage indexes with loc_hc[9:2]/loc_vc[9:2] (4x scale).
// PARAMETERS
//  SPR_W       30    sprite width in ROM texels
//  SPR_H       7     sprite height in ROM texels
//  SCALE_LOG2  2     texel = 2^SCALE_LOG2 screen pixels per axis (window 120x28)
//  H_ACTIVE    640   visible columns
//  FLOOR_Y     440   resting top-row y (screen px)
//  DROP_STEP   4     px moved down per frame while falling
//  LIFETIME    600   resting frames before expiry (BLINK_EN only)
// PORTS
//  CLK          in   1   pixel clock
//  RST_N        in   1   asynchronous, active-low reset
//  hc           in   10  beam column from VGA sync
//  vc           in   10  beam row from VGA sync
//  frame_tick   in   1   1-cycle pulse at vertical-blank start
//  spawn        in   1   1-cycle pulse: drop article at spawn_x/spawn_y
//  spawn_x      in   10  spawn column (screen px, top-left)
//  spawn_y      in   10  spawn row (screen px, top-left)
//  collect      in   1   1-cycle pulse: player picked article up
//  is_in_pixel  out  1   beam inside visible sprite window (registered)
//  loc_hc       out  10  hc - pos_x, valid when is_in_pixel, else 0
//  loc_vc       out  10  vc - pos_y, valid when is_in_pixel, else 0
//  active       out  1   state != IDLE
//  pos_x        out  10  current top-left column
//  pos_y        out  10  current top-left row
// BEHAVIOUR
//  Reset: state=IDLE; pos_x=pos_y=0; is_in_pixel=0; loc_hc=loc_vc=0; active=0.
//  FSM: IDLE -spawn-> FALLING -(landed)-> RESTING -collect-> IDLE. collect in FALLING also goes to IDLE.
//  spawn in any state: reload position and enter FALLING (restart). spawn and collect in the same cycle: spawn wins.
//  Spawn clamps: pos_x=min(spawn_x, H_ACTIVE-(SPR_W<<SCALE_LOG2)); pos_y=min(spawn_y, FLOOR_Y).
//   If the clamped y equals FLOOR_Y, enter RESTING directly.
//  Motion is applied on frame_tick only; no tear mid-frame.
//   FALLING: if pos_y+DROP_STEP >= FLOOR_Y, then pos_y=FLOOR_Y and state=RESTING; else pos_y += DROP_STEP.
//   Do the add at 11 bits (no wrap).
//  collect and frame_tick in the same cycle: collect wins; no move.
//  Hit test (combinational, registered once, 1-cycle latency from hc/vc):
//   hc in [pos_x, pos_x+(SPR_W<<SCALE_LOG2)) and vc in [pos_y, pos_y+(SPR_H<<SCALE_LOG2)) and state!=IDLE.
//   Upper bounds use 11-bit sums. Outputs for beam (hc,vc) at cycle N appear at cycle N+1.
//  Downstream must delay its hc-derived RGB path by 1 cycle to match.
//  Reset asserted mid-frame: all outputs drop to reset values immediately (async); article is lost.
// CONFIGURATION
//  WEAPON_ARTICLE_BLINK_EN defined:
//   - A 10-bit frame counter clears on entry to RESTING and counts frame_tick in RESTING.
//   - Once the counter reaches LIFETIME-64, is_in_pixel is forced 0 whenever cnt[3]=1 (8-frame blink).
//   - At cnt==LIFETIME-1 plus frame_tick, the article expires: state=IDLE.
//  Undefined: no counter. RESTING persists until collect or spawn. is_in_pixel is never masked.
// STRUCTURE
//  sprite_pkg: state encoding (IDLE=2'd0, FALLING=2'd1, RESTING=2'd2), SCALE_LOG2 default, 11-bit coordinate width constant.
//  Sub-module sprite_window_hit: pure combinational window compare (pos, size, beam -> hit, local x/y).
//   Reusable by other sprite locators. FSM and output registers stay in this module.
// TESTING
//  1 Reset: RST_N=0 mid-frame -> is_in_pixel=0, active=0, pos=0 on the same cycle.
//  2 spawn x=100,y=400, 10 frame_ticks, DROP_STEP=4 -> pos_y=440 after tick 10, state RESTING, no overshoot.
//  3 Resting at (100,440), beam hc=100,vc=440 -> next cycle is_in_pixel=1, loc=(0,0).
//    Beam hc=219 -> loc_hc=119. Beam hc=220 or vc=468 -> 0.
//  4 spawn_x=600 -> pos_x clamped to 520. spawn_y=470 -> pos_y=440, direct RESTING.
//  5 collect with frame_tick same cycle while FALLING -> IDLE, pos unchanged.
//    spawn with collect same cycle -> FALLING at new pos.
//  6 BLINK_EN: rest 600 frames -> blink masks in frames 536..599 when cnt[3]=1; IDLE after frame 600.
//    Without the macro -> still RESTING after 1000 frames.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite-locator types: FSM state encoding, default texel scale and
// the widened coordinate width used for overflow-free window arithmetic.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALLING = 2'd1,
    ST_RESTING = 2'd2
  } state_t;

  localparam int SCALE_LOG2_DEF = 2;
  localparam int COORD_W        = 11;

endpackage

// File: rtl/sprite_window_hit.sv
// Combinational beam-vs-sprite-window compare. Bounds are evaluated at
// COORD_W bits so a window near the screen edge cannot wrap.
module sprite_window_hit
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 30,
  parameter int SPR_H      = 7,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF
) (
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic       hit,
  output logic [9:0] loc_x,
  output logic [9:0] loc_y
);

  localparam logic [COORD_W-1:0] WIN_W = COORD_W'(SPR_W << SCALE_LOG2);
  localparam logic [COORD_W-1:0] WIN_H = COORD_W'(SPR_H << SCALE_LOG2);

  logic [COORD_W-1:0] hc_w_s;
  logic [COORD_W-1:0] vc_w_s;
  logic [COORD_W-1:0] x_lo_s;
  logic [COORD_W-1:0] y_lo_s;
  logic [COORD_W-1:0] x_hi_s;
  logic [COORD_W-1:0] y_hi_s;
  logic               in_x_s;
  logic               in_y_s;

  // Half-open window test on both axes plus sprite-local offsets.
  always_comb begin
    hc_w_s = COORD_W'(hc);
    vc_w_s = COORD_W'(vc);
    x_lo_s = COORD_W'(pos_x);
    y_lo_s = COORD_W'(pos_y);
    x_hi_s = x_lo_s + WIN_W;
    y_hi_s = y_lo_s + WIN_H;
    in_x_s = (hc_w_s >= x_lo_s) && (hc_w_s < x_hi_s);
    in_y_s = (vc_w_s >= y_lo_s) && (vc_w_s < y_hi_s);
    hit    = in_x_s && in_y_s;
    loc_x  = hc - pos_x;
    loc_y  = vc - pos_y;
  end

endmodule

// File: rtl/weapon_article_locator.sv
// Dropped-weapon sprite locator: hidden/falling/resting lifecycle plus a
// registered beam hit test. Optional expiry blink: WEAPON_ARTICLE_BLINK_EN.
module weapon_article_locator
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 30,
  parameter int SPR_H      = 7,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter int H_ACTIVE   = 640,
  parameter int FLOOR_Y    = 440,
  parameter int DROP_STEP  = 4,
  parameter int LIFETIME   = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       collect,
  output logic       is_in_pixel,
  output logic [9:0] loc_hc,
  output logic [9:0] loc_vc,
  output logic       active,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  localparam logic [9:0]         X_MAX   = 10'(H_ACTIVE - (SPR_W << SCALE_LOG2));
  localparam logic [9:0]         FLOOR   = 10'(FLOOR_Y);
  localparam logic [COORD_W-1:0] FLOOR_W = COORD_W'(FLOOR_Y);
  localparam logic [COORD_W-1:0] STEP_W  = COORD_W'(DROP_STEP);

  state_t             state_r;
  logic [9:0]         pos_x_r;
  logic [9:0]         pos_y_r;
  logic               is_in_pixel_r;
  logic [9:0]         loc_hc_r;
  logic [9:0]         loc_vc_r;

  logic [9:0]         spawn_x_cl_s;
  logic [9:0]         spawn_y_cl_s;
  logic [COORD_W-1:0] fall_sum_s;
  logic               hit_s;
  logic [9:0]         hit_x_s;
  logic [9:0]         hit_y_s;
  logic               expire_s;
  logic               mask_s;
  logic               live_hit_s;

  sprite_window_hit #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .SCALE_LOG2 (SCALE_LOG2)
  ) u_hit (
    .pos_x (pos_x_r),
    .pos_y (pos_y_r),
    .hc    (hc),
    .vc    (vc),
    .hit   (hit_s),
    .loc_x (hit_x_s),
    .loc_y (hit_y_s)
  );

`ifdef WEAPON_ARTICLE_BLINK_EN
  localparam logic [9:0] BLINK_START = 10'(LIFETIME - 64);
  localparam logic [9:0] LAST_FRAME  = 10'(LIFETIME - 1);

  logic [9:0] cnt_r;

  // Resting-frame counter; zero whenever not resting, so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 10'd0;
    end else if (spawn || (state_r != ST_RESTING)) begin
      cnt_r <= 10'd0;
    end else if (frame_tick) begin
      cnt_r <= cnt_r + 10'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry and the late-life 8-frame blink.
  always_comb begin
    expire_s = (state_r == ST_RESTING) && (cnt_r == LAST_FRAME);
    mask_s   = (state_r == ST_RESTING) && (cnt_r >= BLINK_START) && cnt_r[3];
  end
`else
  // Without the lifetime feature the article never expires or blinks.
  always_comb begin
    expire_s = 1'b0;
    mask_s   = 1'b0;
  end
`endif

  // Spawn clamping and the widened falling step.
  always_comb begin
    if (spawn_x > X_MAX) begin
      spawn_x_cl_s = X_MAX;
    end else begin
      spawn_x_cl_s = spawn_x;
    end
    if (spawn_y > FLOOR) begin
      spawn_y_cl_s = FLOOR;
    end else begin
      spawn_y_cl_s = spawn_y;
    end
    fall_sum_s = COORD_W'(pos_y_r) + STEP_W;
    live_hit_s = hit_s && (state_r != ST_IDLE) && !mask_s;
  end

  // Lifecycle FSM; spawn beats collect, collect beats frame motion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pos_x_r <= 10'd0;
      pos_y_r <= 10'd0;
    end else if (spawn) begin
      pos_x_r <= spawn_x_cl_s;
      pos_y_r <= spawn_y_cl_s;
      state_r <= (spawn_y_cl_s == FLOOR) ? ST_RESTING : ST_FALLING;
    end else if (collect) begin
      state_r <= ST_IDLE;
    end else if (frame_tick) begin
      case (state_r)
        ST_FALLING: begin
          if (fall_sum_s >= FLOOR_W) begin
            pos_y_r <= FLOOR;
            state_r <= ST_RESTING;
          end else begin
            pos_y_r <= fall_sum_s[9:0];
          end
        end
        ST_RESTING: begin
          if (expire_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= state_r;
        end
      endcase
    end
  end

  // One-cycle registered hit outputs; offsets are zeroed outside the sprite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_in_pixel_r <= 1'b0;
      loc_hc_r      <= 10'd0;
      loc_vc_r      <= 10'd0;
    end else begin
      is_in_pixel_r <= live_hit_s;
      loc_hc_r      <= live_hit_s ? hit_x_s : 10'd0;
      loc_vc_r      <= live_hit_s ? hit_y_s : 10'd0;
    end
  end

  assign is_in_pixel = is_in_pixel_r;
  assign loc_hc      = loc_hc_r;
  assign loc_vc      = loc_vc_r;
  assign active      = (state_r != ST_IDLE);
  assign pos_x       = pos_x_r;
  assign pos_y       = pos_y_r;

endmodule
